irq_pend: RTL

Request-capture stage that sits directly upstream of the 4-to-2 priority encoder `enc4`. It turns raw level request lines into sticky, maskable pending bits. It drives the `pend` vector into the encoder's `i` input, and it runs a small request/acknowledge state machine toward the consumer. The consumer returns the encoder's index output `o` as `ack_idx`, and each acknowledge retires exactly one pending bit.

---
 rtl/irq_pend_if.sv | 41 ++++
 rtl/irq_pend.sv | 137 +++++++++++++
 2 files changed

// File: rtl/irq_pend_if.sv
// irq_pend_if: bundles the request/acknowledge signals exchanged between the
// irq_pend capture stage and its consumer (typically enc4 plus a service FSM).
//
// Signals:
//   src      raw request levels, synchronous to clk
//   mask     per-line enable (1 = enabled)
//   ack      acknowledge strobe from the consumer
//   ack_idx  index being acknowledged (driven from enc4.o)
//   clr_ovf  clears all overflow flags
//   pend     masked pending vector (feeds enc4.i)
//   irq      service request to the consumer
//   busy     high whenever the capture FSM is not idle
//   ovf      sticky per-line overflow flags
//
// Modports:
//   master   consumer side (drives requests/acks, observes status)
//   slave    irq_pend side
interface irq_pend_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic [N-1:0]  src;
    logic [N-1:0]  mask;
    logic          ack;
    logic [IW-1:0] ack_idx;
    logic          clr_ovf;
    logic [N-1:0]  pend;
    logic          irq;
    logic          busy;
    logic [N-1:0]  ovf;

    modport master (
        output src, mask, ack, ack_idx, clr_ovf,
        input  pend, irq, busy, ovf
    );

    modport slave (
        input  src, mask, ack, ack_idx, clr_ovf,
        output pend, irq, busy, ovf
    );
endinterface

// File: rtl/irq_pend.sv
// irq_pend: request-capture stage in front of the enc4 priority encoder.
// Turns raw level request lines into sticky, maskable pending bits, flags
// events that arrive while a line is already pending, and runs a small
// IDLE/ASSERT/HOLD handshake toward the consumer. Each acknowledge retires
// one pending bit and forces HOLDOFF idle cycles before irq can reassert.
//
// Ports:
//   clk    single clock, all state changes on its rising edge
//   rst_n  synchronous active-low reset
//   bus    irq_pend_if.slave (src, mask, ack, ack_idx, clr_ovf in;
//          pend, irq, busy, ovf out)
//
// Parameters:
//   N        number of request lines (4 when paired with enc4)
//   IW       index width, clog2(N)
//   HOLDOFF  idle cycles forced after each acknowledge, 1..15
module irq_pend #(
    parameter int N       = 4,
    parameter int IW      = 2,
    parameter int HOLDOFF = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    irq_pend_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  src_q;
    logic [N-1:0]  p;
    logic [N-1:0]  ovf_q;
    logic [3:0]    hcnt;

    logic [N-1:0]  rise;
    logic [N-1:0]  clr;
    logic [N-1:0]  ovf_set;
    logic [N-1:0]  pend_v;
    logic          any_pend;
    logic          ack_take;

    // Only an ack seen in ASSERT has any effect; in IDLE/HOLD it is ignored.
    assign ack_take = (state == S_ASSERT) && bus.ack;

    assign rise     = bus.src & ~src_q;
    assign pend_v   = p & bus.mask;
    assign any_pend = |pend_v;
    // Overflow: a new event merged into a bit that is pending and not being
    // retired this cycle.
    assign ovf_set  = rise & p & ~clr;

    // Decode the acknowledged index. An out-of-range index matches no bit,
    // so the ack still moves the FSM to HOLD but clears nothing.
    always_comb begin
        // NOTE: every combinationally driven variable gets a default before
        // any conditional assignment so no latch is inferred.
        clr = '0;
        for (int j = 0; j < N; j++) begin
            if (ack_take && (bus.ack_idx == IW'(j))) begin
                clr[j] = 1'b1;
            end
        end
    end

    // Datapath registers: edge history, pending, overflow, holdoff counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            src_q <= '0;
            p     <= '0;
            ovf_q <= '0;
            hcnt  <= '0;
        end else begin
            src_q <= bus.src;
            // Set wins over clear: a new event in the ack cycle is kept.
            p     <= rise | (p & ~clr);
            // Set wins over clr_ovf as well.
            ovf_q <= ovf_set | (ovf_q & ~{N{bus.clr_ovf}});
            if (ack_take) begin
                hcnt <= 4'(HOLDOFF - 1);
            end else if ((state == S_HOLD) && (hcnt != 4'd0)) begin
                hcnt <= hcnt - 4'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (any_pend) begin
                    state_nxt = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (bus.ack) begin
                    state_nxt = S_HOLD;
                end else if (!any_pend) begin
                    state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                // hcnt is loaded with HOLDOFF-1, so HOLD lasts HOLDOFF cycles.
                if (hcnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the registered state only (glitch-free).
    always_comb begin
        bus.irq  = (state == S_ASSERT);
        bus.busy = (state != S_IDLE);
    end

    assign bus.pend = pend_v;
    assign bus.ovf  = ovf_q;

endmodule
